// File: rtl/pq_pkg.sv
// Shared types for the priority-queue front-end scheduler.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package pq_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE
  } state_t;

  // Operation chosen in IDLE for the current cycle.
  typedef enum logic [2:0] {
    OP_NONE,
    OP_ENQ,
    OP_DEQ,
    OP_REPLACE,
    OP_MISS
  } op_t;

  // Width of the settle down-counter; it only has to hold SETTLE_CYCLES-1.
  function automatic int cnt_width(input int settle_cycles);
    return (settle_cycles <= 2) ? 1 : $clog2(settle_cycles);
  endfunction

endpackage

// File: rtl/pq_scheduler_if.sv
// Handshake, result and queue-command bundle for pq_scheduler.
// Latency: n/a (wires only).
// Backpressure: carries valid/ready pairs; no storage of its own.
interface pq_scheduler_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  i_enq_valid;
  logic                  o_enq_ready;
  logic [DATA_WIDTH-1:0] i_enq_data;
  logic                  i_deq_req_valid;
  logic                  o_deq_req_ready;
  logic                  o_deq_valid;
  logic                  i_deq_ready;
  logic [DATA_WIDTH-1:0] o_deq_data;
  logic                  o_deq_miss;
  logic                  o_zero_drop;
  logic                  o_pq_wrt;
  logic                  o_pq_read;
  logic [DATA_WIDTH-1:0] o_pq_data;
  logic                  i_pq_full;
  logic                  i_pq_empty;
  logic [DATA_WIDTH-1:0] i_pq_data;
  logic                  o_busy;

  // Scheduler side.
  modport slave (
    input  i_enq_valid, i_enq_data, i_deq_req_valid, i_deq_ready,
    input  i_pq_full, i_pq_empty, i_pq_data,
    output o_enq_ready, o_deq_req_ready, o_deq_valid, o_deq_data, o_deq_miss,
    output o_zero_drop, o_pq_wrt, o_pq_read, o_pq_data, o_busy
  );

  // Upstream producer/consumer plus the queue itself.
  modport master (
    output i_enq_valid, i_enq_data, i_deq_req_valid, i_deq_ready,
    output i_pq_full, i_pq_empty, i_pq_data,
    input  o_enq_ready, o_deq_req_ready, o_deq_valid, o_deq_data, o_deq_miss,
    input  o_zero_drop, o_pq_wrt, o_pq_read, o_pq_data, o_busy
  );
endinterface

// File: rtl/pq_hold_reg.sv
// Single-entry valid/ready holding register; entries flagged in_drop are accepted but not stored.
// Latency: stored entry visible the cycle after the handshake; no same-cycle bypass.
// Backpressure: in_rdy low while the entry is held, until the consumer pulses clr.
module pq_hold_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic         in_drop,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         clr
);
  logic         full_q;
  logic [W-1:0] dat_q;

  assign in_rdy  = !full_q;
  assign out_vld = full_q;
  assign out_dat = dat_q;

  // Load on handshake, empty when the consumer takes the entry (never both: clr needs full, load needs empty).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      dat_q  <= '0;
    end else if (clr) begin
      full_q <= 1'b0;
    end else if (in_vld && !full_q && !in_drop) begin
      full_q <= 1'b1;
      dat_q  <= in_dat;
    end
  end
endmodule

// File: rtl/pq_scheduler.sv
// Front-end scheduler issuing write/read/replace commands to a register-tree max-heap, with a settle gap.
// Latency: handshake N -> strobe N+2 -> result N+3 (miss result N+2); commands spaced SETTLE_CYCLES+2.
// Backpressure: one holder per request channel; dequeues wait while the result register is occupied.
module pq_scheduler
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int QUEUE_SIZE    = 15,
  parameter int SETTLE_CYCLES = 2 * $clog2(QUEUE_SIZE)
) (
  input logic           i_CLK,
  input logic           i_RST,
  pq_scheduler_if.slave bus
);
  localparam int            CW          = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  state_t                state;
  logic [CW-1:0]         settle_cnt;
  op_t                   op_sel;
  logic                  enq_held, deq_held, enq_clr, deq_clr;
  logic                  enq_is_zero, res_free;
  logic [DATA_WIDTH-1:0] enq_val;
  logic                  unused_deq_dat;
  logic                  pq_wrt_q, pq_read_q;
  logic [DATA_WIDTH-1:0] pq_data_q, deq_data_q;
  logic                  deq_valid_q, deq_miss_q, zero_drop_q;

  // A zero is the heap's empty sentinel, so it is swallowed at the holder.
  assign enq_is_zero = (bus.i_enq_data == '0);
  assign res_free    = !deq_valid_q || bus.i_deq_ready;

  pq_hold_reg #(.W(DATA_WIDTH)) u_enq_hold (
    .clk(i_CLK), .rst(i_RST),
    .in_vld(bus.i_enq_valid), .in_drop(enq_is_zero), .in_dat(bus.i_enq_data),
    .in_rdy(bus.o_enq_ready), .out_vld(enq_held), .out_dat(enq_val), .clr(enq_clr)
  );

  pq_hold_reg #(.W(1)) u_deq_hold (
    .clk(i_CLK), .rst(i_RST),
    .in_vld(bus.i_deq_req_valid), .in_drop(1'b0), .in_dat(1'b0),
    .in_rdy(bus.o_deq_req_ready), .out_vld(deq_held), .out_dat(unused_deq_dat), .clr(deq_clr)
  );

  // Pick the operation in IDLE; queue status is only trusted here, after any settle gap.
  always_comb begin
    op_sel = OP_NONE;
    if (state == ST_IDLE) begin
      if (enq_held && deq_held && !bus.i_pq_empty && res_free)      op_sel = OP_REPLACE;
      else if (deq_held && bus.i_pq_empty && !enq_held && res_free) op_sel = OP_MISS;
      else if (deq_held && !bus.i_pq_empty && res_free)             op_sel = OP_DEQ;
      else if (enq_held && !bus.i_pq_full)                          op_sel = OP_ENQ;
    end
  end

  assign enq_clr = (op_sel == OP_ENQ) || (op_sel == OP_REPLACE);
  assign deq_clr = (op_sel == OP_DEQ) || (op_sel == OP_REPLACE) || (op_sel == OP_MISS);

  // Flag a discarded zero-valued enqueue for one cycle after its handshake.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) zero_drop_q <= 1'b0;
    else       zero_drop_q <= bus.i_enq_valid && bus.o_enq_ready && enq_is_zero;
  end

  // Result register: root captured at the end of a read ISSUE, zero+miss on an empty-queue request.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      deq_valid_q <= 1'b0;
      deq_data_q  <= '0;
      deq_miss_q  <= 1'b0;
    end else if (state == ST_ISSUE && pq_read_q) begin
      deq_valid_q <= 1'b1;
      deq_data_q  <= bus.i_pq_data;
      deq_miss_q  <= 1'b0;
    end else if (op_sel == OP_MISS) begin
      deq_valid_q <= 1'b1;
      deq_data_q  <= '0;
      deq_miss_q  <= 1'b1;
    end else if (deq_valid_q && bus.i_deq_ready) begin
      deq_valid_q <= 1'b0;
    end
  end

  // Command FSM: one-cycle ISSUE with registered strobes, then SETTLE_CYCLES idle cycles.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      pq_wrt_q   <= 1'b0;
      pq_read_q  <= 1'b0;
      pq_data_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_sel == OP_ENQ || op_sel == OP_DEQ || op_sel == OP_REPLACE) begin
            state     <= ST_ISSUE;
            pq_wrt_q  <= (op_sel == OP_ENQ) || (op_sel == OP_REPLACE);
            pq_read_q <= (op_sel == OP_DEQ) || (op_sel == OP_REPLACE);
            if (op_sel != OP_DEQ) pq_data_q <= enq_val;
          end
        end
        ST_ISSUE: begin
          state      <= ST_SETTLE;
          pq_wrt_q   <= 1'b0;
          pq_read_q  <= 1'b0;
          settle_cnt <= SETTLE_LOAD;
        end
        default: begin
          if (settle_cnt == '0) state      <= ST_IDLE;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
      endcase
    end
  end

  assign bus.o_pq_wrt    = pq_wrt_q;
  assign bus.o_pq_read   = pq_read_q;
  assign bus.o_pq_data   = pq_data_q;
  assign bus.o_deq_valid = deq_valid_q;
  assign bus.o_deq_data  = deq_data_q;
  assign bus.o_deq_miss  = deq_miss_q;
  assign bus.o_zero_drop = zero_drop_q;
  assign bus.o_busy      = (state != ST_IDLE);
endmodule
